// File: rtl/flt_pkg.sv
// Shared half-precision definitions for the float datapath blocks.
package flt_pkg;

  localparam int unsigned BIAS   = 15;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MANT_W = 10;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } half_t;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StNorm,
    StRnd,
    StWrLo,
    StWrHi
  } conv_state_e;

endpackage

// File: rtl/flt_round_rne.sv
// Round-to-nearest-even on a normalised half mantissa. Purely combinational.
// A mantissa carry-out renormalises by bumping the exponent.
module flt_round_rne
  import flt_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp,
  input  logic              guard,
  input  logic              round_bit,
  input  logic              sticky,
  output logic [MANT_W-1:0] rnd_mant,
  output logic [EXP_W-1:0]  rnd_exp
);

  logic inc;

  // Increment above half-way, or exactly half-way with an odd lsb.
  always_comb begin
    inc      = guard & (round_bit | sticky | mant[0]);
    rnd_mant = mant;
    rnd_exp  = exp;
    if (inc) begin
      if (&mant) begin
        rnd_mant = '0;
        rnd_exp  = exp + 5'd1;
      end else begin
        rnd_mant = mant + 10'd1;
      end
    end
  end

endmodule

// File: rtl/int_to_flt_conv.sv
// Multi-cycle int16 -> half-precision converter working through byte-wide data_mem.
// Reads the integer little-endian, normalises one bit per cycle, rounds, then writes
// the float back little-endian. All memory-side outputs are registered and set on the
// edge that enters the state using them.
module int_to_flt_conv
  import flt_pkg::*;
#(
  parameter int unsigned SRC_ADDR = 0,
  parameter int unsigned DST_ADDR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [7:0] SrcLo = 8'(SRC_ADDR);
  localparam logic [7:0] SrcHi = 8'(SRC_ADDR + 1);
  localparam logic [7:0] DstLo = 8'(DST_ADDR);
  localparam logic [7:0] DstHi = 8'(DST_ADDR + 1);
  // Exponent of a magnitude whose msb sits at bit 15.
  localparam logic [4:0] ExpTop = 5'(BIAS + 15);

  conv_state_e state;
  logic [7:0]  lo_q;
  logic        sign_q;
  logic [15:0] mag_q;
  logic [4:0]  exp_q;
  half_t       res_q;

  logic [15:0] in_word;
  logic [15:0] in_mag;
  logic [9:0]  rnd_mant;
  logic [4:0]  rnd_exp;

  // Assemble the integer and take its magnitude; -32768 wraps to 0x8000, still correct.
  always_comb begin
    in_word = {mem_rdata, lo_q};
    in_mag  = in_word[15] ? (~in_word + 16'd1) : in_word;
  end

  flt_round_rne u_round (
    .mant     (mag_q[14:5]),
    .exp      (exp_q),
    .guard    (mag_q[4]),
    .round_bit(mag_q[3]),
    .sticky   (|mag_q[2:0]),
    .rnd_mant (rnd_mant),
    .rnd_exp  (rnd_exp)
  );

  // Conversion sequencer with registered memory interface and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      lo_q      <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      res_q     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            done     <= 1'b0;
            mem_addr <= SrcLo;
            mem_rd   <= 1'b1;
            state    <= StRdLo;
          end
        end
        StRdLo: begin
          lo_q     <= mem_rdata;
          mem_addr <= SrcHi;
          state    <= StRdHi;
        end
        StRdHi: begin
          mem_rd <= 1'b0;
          sign_q <= in_word[15];
          mag_q  <= in_mag;
          exp_q  <= ExpTop;
          if (in_mag == 16'd0) begin
            res_q     <= '0;
            mem_wr    <= 1'b1;
            mem_addr  <= DstLo;
            mem_wdata <= 8'h00;
            state     <= StWrLo;
          end else begin
            mem_addr <= '0;
            state    <= StNorm;
          end
        end
        StNorm: begin
          if (mag_q[15]) begin
            state <= StRnd;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 5'd1;
          end
        end
        StRnd: begin
          res_q     <= '{sign: sign_q, exp: rnd_exp, mant: rnd_mant};
          mem_wr    <= 1'b1;
          mem_addr  <= DstLo;
          mem_wdata <= rnd_mant[7:0];
          state     <= StWrLo;
        end
        StWrLo: begin
          mem_addr  <= DstHi;
          mem_wdata <= res_q[15:8];
          state     <= StWrHi;
        end
        StWrHi: begin
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          done      <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
